serial_addsub_acc: RTL and testbench

- Parametrised successor to the single-bit half-adder datapath: a digit-serial adder/subtractor with an optional running accumulator.
- Processes DIGIT bits per clock, carrying between digits through a carry register.
- Uses a valid/ready handshake on both input and output.
- Sits between the tile I/O wrapper and downstream logic as a small-area arithmetic unit for the project top.

---
 rtl/serial_addsub_acc_if.sv | 25 ++
 rtl/serial_addsub_acc.sv | 129 ++++++++++++
 tb/tb_serial_addsub_acc.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_addsub_acc_if.sv
// Command/result bundle for the digit-serial add/sub unit.
// The master is the upstream side that issues commands and takes results.
interface serial_addsub_acc_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, op_a, op_b, mode, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow, zero
  );

  modport slave (
    input  in_valid, op_a, op_b, mode, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow, zero
  );
endinterface

// File: rtl/serial_addsub_acc.sv
// Digit-serial adder/subtractor with an optional running accumulator.
// DIGIT bits per cycle, LSB first; the result is assembled from the MSB end.
module serial_addsub_acc #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  serial_addsub_acc_if.slave io
);
  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic [WIDTH-1:0]   acc_q, acc_d, sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d, acc_mode_q, acc_mode_d;
  logic               cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

  logic [DIGIT-1:0]   dsum;
  logic               dcarry, dcarry_msb;
  logic [WIDTH-1:0]   res_next;
  logic               last;

  // Ripple add of one digit; the carry into the top bit feeds the overflow flag.
  always_comb begin
    logic c;
    c          = carry_q;
    dcarry_msb = carry_q;
    dsum       = '0;
    for (int i = 0; i < DIGIT; i++) begin
      dcarry_msb = c;
      dsum[i]    = a_q[i] ^ b_q[i] ^ c;
      c          = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
    end
    dcarry = c;
  end

  assign res_next = (res_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
  assign last     = (cnt_q == CNT_W'(N - 1));

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    acc_d      = acc_q;
    sum_d      = sum_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    acc_mode_d = acc_mode_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    zero_d     = zero_q;
    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          // Subtract is A + ~B + 1: invert B here and seed the carry with 1.
          a_d        = io.mode[1] ? acc_q : io.op_a;
          b_d        = io.mode[0] ? ~io.op_b : io.op_b;
          carry_d    = io.mode[0];
          acc_mode_d = io.mode[1];
          cnt_d      = '0;
          res_d      = '0;
          state_d    = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        res_d   = res_next;
        carry_d = dcarry;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last) begin
          sum_d   = res_next;
          cout_d  = dcarry;
          ovf_d   = dcarry_msb ^ dcarry;
          zero_d  = (res_next == '0);
          if (acc_mode_q) acc_d = res_next;
          state_d = DONE;
        end
      end
      DONE: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      acc_q      <= '0;
      sum_q      <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      acc_mode_q <= 1'b0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      acc_q      <= acc_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      acc_mode_q <= acc_mode_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
      zero_q     <= zero_d;
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.sum       = sum_q;
  assign io.carry_out = cout_q;
  assign io.overflow  = ovf_q;
  assign io.zero      = zero_q;
endmodule

// File: tb/tb_serial_addsub_acc.sv
// Directed + random bench for serial_addsub_acc; DIGIT=1, 4 and 8 instances run in lockstep.
module tb_serial_addsub_acc;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iv = 1'b0, ordy = 1'b1;
  logic [1:0] md = '0;
  logic [7:0] a = '0, b = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_addsub_acc_if #(.WIDTH(8)) if1 ();
  serial_addsub_acc_if #(.WIDTH(8)) if4 ();
  serial_addsub_acc_if #(.WIDTH(8)) if8 ();

  assign if1.in_valid = iv;  assign if1.op_a = a;  assign if1.op_b = b;
  assign if1.mode = md;      assign if1.out_ready = ordy;
  assign if4.in_valid = iv;  assign if4.op_a = a;  assign if4.op_b = b;
  assign if4.mode = md;      assign if4.out_ready = ordy;
  assign if8.in_valid = iv;  assign if8.op_a = a;  assign if8.op_b = b;
  assign if8.mode = md;      assign if8.out_ready = ordy;

  serial_addsub_acc #(.WIDTH(8), .DIGIT(1)) u1 (.clk(clk), .rst(rst), .io(if1));
  serial_addsub_acc #(.WIDTH(8), .DIGIT(4)) u4 (.clk(clk), .rst(rst), .io(if4));
  serial_addsub_acc #(.WIDTH(8), .DIGIT(8)) u8 (.clk(clk), .rst(rst), .io(if8));

  typedef struct {
    logic [1:0] md;
    logic [7:0] a, b, sum;
    logic       co, ov, z;
  } vec_t;

  vec_t       vt[13];
  logic [7:0] r_sum[3];
  logic       r_co[3], r_ov[3], r_z[3];
  int         lat[3];
  int         exp_lat[3] = '{8, 2, 1};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Snapshot of one DUT's visible outputs, indexed 0/1/2 for DIGIT 1/4/8.
  task automatic peek(input int d, output logic rdy, output logic vld,
                      output logic [7:0] s, output logic co, output logic ov, output logic z);
    case (d)
      0:       begin rdy = if1.in_ready; vld = if1.out_valid; s = if1.sum; co = if1.carry_out; ov = if1.overflow; z = if1.zero; end
      1:       begin rdy = if4.in_ready; vld = if4.out_valid; s = if4.sum; co = if4.carry_out; ov = if4.overflow; z = if4.zero; end
      default: begin rdy = if8.in_ready; vld = if8.out_valid; s = if8.sum; co = if8.carry_out; ov = if8.overflow; z = if8.zero; end
    endcase
  endtask

  task automatic chk_state(input string tag, input logic e_rdy, input logic e_vld);
    logic rdy, vld, co, ov, z;
    logic [7:0] s;
    for (int d = 0; d < 3; d++) begin
      peek(d, rdy, vld, s, co, ov, z);
      chk($sformatf("%s_d%0d_in_ready", tag, d), rdy, e_rdy);
      chk($sformatf("%s_d%0d_out_valid", tag, d), vld, e_vld);
    end
  endtask

  // Called on the negedge after the accept edge; records first out_valid per DUT.
  task automatic collect();
    logic rdy, vld, co, ov, z;
    logic [7:0] s;
    for (int d = 0; d < 3; d++) lat[d] = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
        peek(d, rdy, vld, s, co, ov, z);
        if (vld && lat[d] < 0) begin
          lat[d] = k; r_sum[d] = s; r_co[d] = co; r_ov[d] = ov; r_z[d] = z;
        end
      end
    end
  endtask

  task automatic do_op(input logic [1:0] m, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    chk_state("pre_op", 1'b1, 1'b0);
    md = m; a = x; b = y; iv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv = 1'b0;
    collect();
  endtask

  task automatic check_res(input string tag, input logic [7:0] es, input logic eco,
                           input logic eov, input logic ez);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_d%0d_latency", tag, d), lat[d], exp_lat[d]);
      chk($sformatf("%s_d%0d_sum", tag, d), r_sum[d], es);
      chk($sformatf("%s_d%0d_carry", tag, d), r_co[d], eco);
      chk($sformatf("%s_d%0d_ovf", tag, d), r_ov[d], eov);
      chk($sformatf("%s_d%0d_zero", tag, d), r_z[d], ez);
    end
  endtask

  initial begin
    logic [7:0] acc_m, oa, ob, es;
    logic [8:0] full;
    logic rdy, vld, co, ov, z;
    logic [7:0] s;

    vt[0]  = '{2'b00, 8'h3C, 8'h45, 8'h81, 1'b0, 1'b1, 1'b0};
    vt[1]  = '{2'b01, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{2'b00, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1};
    vt[3]  = '{2'b01, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0};
    vt[4]  = '{2'b00, 8'hF7, 8'h19, 8'h10, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    vt[6]  = '{2'b01, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1};
    vt[7]  = '{2'b00, 8'h7F, 8'h7F, 8'hFE, 1'b0, 1'b1, 1'b0};
    // Accumulator chain from acc=0; op_a values are junk that must be ignored.
    vt[8]  = '{2'b10, 8'hAA, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{2'b10, 8'h55, 8'h07, 8'h0C, 1'b0, 1'b0, 1'b0};
    vt[10] = '{2'b11, 8'hFF, 8'd20, 8'hF8, 1'b0, 1'b0, 1'b0};
    vt[11] = '{2'b00, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0};
    vt[12] = '{2'b10, 8'h33, 8'h00, 8'hF8, 1'b0, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_state("reset", 1'b1, 1'b0);
    for (int d = 0; d < 3; d++) begin
      peek(d, rdy, vld, s, co, ov, z);
      chk($sformatf("reset_d%0d_sum", d), s, 0);
      chk($sformatf("reset_d%0d_carry", d), co, 0);
      chk($sformatf("reset_d%0d_ovf", d), ov, 0);
      chk($sformatf("reset_d%0d_zero", d), z, 1);
    end

    for (int i = 0; i < 13; i++) begin
      do_op(vt[i].md, vt[i].a, vt[i].b);
      check_res($sformatf("vec%0d", i), vt[i].sum, vt[i].co, vt[i].ov, vt[i].z);
    end

    // Backpressure: result held, in_valid in DONE ignored until back in IDLE.
    @(negedge clk);
    ordy = 1'b0; md = 2'b00; a = 8'h12; b = 8'h34; iv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 8'h01; b = 8'h01;
    repeat (8) @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk_state($sformatf("bp%0d", c), 1'b0, 1'b1);
      for (int d = 0; d < 3; d++) begin
        peek(d, rdy, vld, s, co, ov, z);
        chk($sformatf("bp%0d_d%0d_sum", c, d), s, 8'h46);
        chk($sformatf("bp%0d_d%0d_flags", c, d), {co, ov, z}, 3'b000);
      end
      @(negedge clk);
    end
    ordy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_state("bp_release", 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    iv = 1'b0;
    chk_state("bp_accept", 1'b0, 1'b0);
    collect();
    check_res("bp_next", 8'h02, 1'b0, 1'b0, 1'b0);

    // Reset during RUN: operation abandoned, accumulator cleared.
    @(negedge clk);
    md = 2'b00; a = 8'hAA; b = 8'h55; iv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_state("midrst", 1'b1, 1'b0);
    for (int d = 0; d < 3; d++) begin
      peek(d, rdy, vld, s, co, ov, z);
      chk($sformatf("midrst_d%0d_sum", d), s, 0);
      chk($sformatf("midrst_d%0d_zero", d), z, 1);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("midrst_idle%0d", c), if1.out_valid, 0);
    end
    do_op(2'b10, 8'h77, 8'h00);
    check_res("acc_cleared", 8'h00, 1'b0, 1'b0, 1'b1);
    do_op(2'b00, 8'h01, 8'h02);
    check_res("post_rst", 8'h03, 1'b0, 1'b0, 1'b0);

    // Random ops in all modes against an unsigned 9-bit reference sum.
    acc_m = 8'h00;
    for (int i = 0; i < 200; i++) begin
      logic [1:0] m;
      logic [7:0] x, y;
      m = 2'($urandom_range(0, 3));
      x = 8'($urandom);
      y = 8'($urandom);
      oa = m[1] ? acc_m : x;
      ob = m[0] ? ~y : y;
      full = {1'b0, oa} + {1'b0, ob} + {8'h00, m[0]};
      es = full[7:0];
      do_op(m, x, y);
      check_res($sformatf("rnd%0d", i), es, full[8],
                (oa[7] == ob[7]) && (es[7] != oa[7]), es == 8'h00);
      if (m[1]) acc_m = es;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
